mfb_frame_gen: RTL and testbench

MFB_FRAME_GEN -- requirements
Module: mfb_frame_gen

---
 rtl/mfb_frame_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_mfb_frame_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfb_frame_gen.sv
// mfb_frame_gen: MFB test-frame source. Frames of incrementing length are
// packed region-aligned into words; every frame carries its sequence number.
module mfb_frame_gen #(
    parameter int REGIONS     = 2,
    parameter int REGION_SIZE = 4,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int META_WIDTH  = 16,
    parameter int LEN_WIDTH   = 16,
    localparam int R  = REGION_SIZE * BLOCK_SIZE,
    localparam int SW = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
    localparam int EW = (R > 1) ? $clog2(R) : 1,
    localparam int DW = REGIONS * R * ITEM_WIDTH
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          START,
    input  logic                          STOP,
    input  logic [31:0]                   FRAME_CNT,
    input  logic [LEN_WIDTH-1:0]          LEN_MIN,
    input  logic [LEN_WIDTH-1:0]          LEN_MAX,
    output logic [DW-1:0]                 TX_DATA,
    output logic [REGIONS*META_WIDTH-1:0] TX_META,
    output logic [REGIONS-1:0]            TX_SOF,
    output logic [REGIONS-1:0]            TX_EOF,
    output logic [REGIONS*SW-1:0]         TX_SOF_POS,
    output logic [REGIONS*EW-1:0]         TX_EOF_POS,
    output logic                          TX_SRC_RDY,
    input  logic                          TX_DST_RDY,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [31:0]                   SENT_FRAMES
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state_q, state_d;
    logic [LEN_WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, off_q, off_d;
    logic [31:0] cnt_q, cnt_d, seq_q, seq_d, sent_q, sent_d;
    logic open_q, open_d, stop_q, stop_d;
    logic vld_q, vld_d, done_q, done_d;
    logic [DW-1:0] data_q, data_d;
    logic [REGIONS*META_WIDTH-1:0] meta_q, meta_d;
    logic [REGIONS-1:0] sof_q, sof_d, eof_q, eof_d;
    logic [REGIONS*EW-1:0] epos_q, epos_d;

    logic start_go, xfer, load;
    logic [LEN_WIDTH-1:0] b_min, b_max;
    logic [31:0] b_cnt;
    logic b_stop;
    logic [31:0] n_seq;
    logic [LEN_WIDTH-1:0] n_len, n_off;
    logic n_open, w_any;
    logic [DW-1:0] w_data;
    logic [REGIONS*META_WIDTH-1:0] w_meta;
    logic [REGIONS-1:0] w_sof, w_eof;
    logic [REGIONS*EW-1:0] w_epos;

    // Build the next word; on START the freshly captured settings are used
    always_comb begin : build
        logic [31:0] seq_v;
        logic [LEN_WIDTH-1:0] len_v, off_v;
        logic open_v;
        start_go = (state_q == IDLE) && START;
        b_min = (LEN_MIN == '0) ? LEN_WIDTH'(1) : LEN_MIN;
        b_max = (LEN_MAX < b_min) ? b_min : LEN_MAX;
        b_cnt = FRAME_CNT;
        b_stop = 1'b0;
        seq_v = '0;
        len_v = b_min;
        off_v = '0;
        open_v = 1'b0;
        if (!start_go) begin
            b_min = min_q;
            b_max = max_q;
            b_cnt = cnt_q;
            b_stop = stop_q | STOP;
            seq_v = seq_q;
            len_v = len_q;
            off_v = off_q;
            open_v = open_q;
        end
        w_data = '0;
        w_meta = '0;
        w_sof = '0;
        w_eof = '0;
        w_epos = '0;
        w_any = 1'b0;
        for (int r = 0; r < REGIONS; r++) begin
            if (!open_v && !b_stop && !(b_cnt != '0 && seq_v == b_cnt)) begin
                w_sof[r] = 1'b1;
                w_meta[r*META_WIDTH +: META_WIDTH] = META_WIDTH'(seq_v);
                open_v = 1'b1;
                off_v = '0;
            end
            if (open_v) begin
                w_any = 1'b1;
                for (int j = 0; j < R; j++) begin
                    if (32'(off_v) + 32'(j) < 32'(len_v))
                        w_data[(r*R+j)*ITEM_WIDTH +: ITEM_WIDTH] =
                            ITEM_WIDTH'(32'(off_v) + 32'(j) + seq_v);
                end
                if (32'(len_v) - 32'(off_v) <= 32'(R)) begin
                    w_eof[r] = 1'b1;
                    w_epos[r*EW +: EW] = EW'(32'(len_v) - 32'(off_v) - 1);
                    open_v = 1'b0;
                    seq_v = seq_v + 1;
                    len_v = (32'(len_v) + 1 > 32'(b_max)) ?
                            b_min : len_v + LEN_WIDTH'(1);
                end else begin
                    off_v = off_v + LEN_WIDTH'(R);
                end
            end
        end
        n_seq = seq_v;
        n_len = len_v;
        n_off = off_v;
        n_open = open_v;
    end

    always_comb begin
        state_d = state_q;
        min_d = min_q;
        max_d = max_q;
        cnt_d = cnt_q;
        len_d = len_q;
        off_d = off_q;
        seq_d = seq_q;
        sent_d = sent_q;
        open_d = open_q;
        stop_d = stop_q;
        vld_d = vld_q;
        done_d = 1'b0;
        data_d = data_q;
        meta_d = meta_q;
        sof_d = sof_q;
        eof_d = eof_q;
        epos_d = epos_q;
        xfer = vld_q & TX_DST_RDY;
        load = start_go || (state_q != IDLE && (xfer || !vld_q));
        if (xfer)
            sent_d = sent_q + 32'($countones(eof_q));
        if (start_go) begin
            min_d = b_min;
            max_d = b_max;
            cnt_d = b_cnt;
            sent_d = '0;
        end
        if (load) begin
            stop_d = b_stop;
            seq_d = n_seq;
            len_d = n_len;
            off_d = n_off;
            open_d = n_open;
            vld_d = w_any;
            data_d = w_data;
            meta_d = w_meta;
            sof_d = w_sof;
            eof_d = w_eof;
            epos_d = w_epos;
            if (!w_any) begin
                state_d = IDLE;
                done_d = 1'b1;
            end else if (b_stop || (b_cnt != '0 &&
                         n_seq + 32'(n_open) == b_cnt)) begin
                state_d = FLUSH;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN && STOP) begin
            stop_d = 1'b1;
            state_d = FLUSH;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            min_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            off_q <= '0;
            seq_q <= '0;
            sent_q <= '0;
            open_q <= 1'b0;
            stop_q <= 1'b0;
            vld_q <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
            meta_q <= '0;
            sof_q <= '0;
            eof_q <= '0;
            epos_q <= '0;
        end else begin
            state_q <= state_d;
            min_q <= min_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            off_q <= off_d;
            seq_q <= seq_d;
            sent_q <= sent_d;
            open_q <= open_d;
            stop_q <= stop_d;
            vld_q <= vld_d;
            done_q <= done_d;
            data_q <= data_d;
            meta_q <= meta_d;
            sof_q <= sof_d;
            eof_q <= eof_d;
            epos_q <= epos_d;
        end
    end

    assign TX_DATA = data_q;
    assign TX_META = meta_q;
    assign TX_SOF = sof_q;
    assign TX_EOF = eof_q;
    assign TX_SOF_POS = '0;
    assign TX_EOF_POS = epos_q;
    assign TX_SRC_RDY = vld_q;
    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;
    assign SENT_FRAMES = sent_q;

endmodule

// File: tb/tb_mfb_frame_gen.sv
// tb_mfb_frame_gen: checks mfb_frame_gen against a frame-list model that
// expands each frame into its regions and matches them word by word.
module tb_mfb_frame_gen;

    localparam int REGIONS = 2;
    localparam int REGION_SIZE = 4;
    localparam int BLOCK_SIZE = 8;
    localparam int ITEM_WIDTH = 8;
    localparam int META_WIDTH = 16;
    localparam int LEN_WIDTH = 16;
    localparam int R = REGION_SIZE * BLOCK_SIZE;
    localparam int SW = $clog2(REGION_SIZE);
    localparam int EW = $clog2(R);
    localparam int RB = R * ITEM_WIDTH;
    localparam int DW = REGIONS * RB;

    typedef logic [RB-1:0] v_t;
    typedef struct packed {
        logic sof;
        logic eof;
        logic [EW-1:0] pos;
        logic [META_WIDTH-1:0] meta;
        logic [RB-1:0] data;
    } reg_t;

    logic clk, rst_n, start, stop, dst_rdy, src_rdy, busy, done;
    logic [31:0] frame_cnt, sent;
    logic [LEN_WIDTH-1:0] len_min, len_max;
    logic [DW-1:0] data;
    logic [REGIONS*META_WIDTH-1:0] meta;
    logic [REGIONS-1:0] sof, eof;
    logic [REGIONS*SW-1:0] sof_pos;
    logic [REGIONS*EW-1:0] eof_pos;

    mfb_frame_gen #(
        .REGIONS(REGIONS), .REGION_SIZE(REGION_SIZE),
        .BLOCK_SIZE(BLOCK_SIZE), .ITEM_WIDTH(ITEM_WIDTH),
        .META_WIDTH(META_WIDTH), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .CLK(clk), .RESET(rst_n), .START(start), .STOP(stop),
        .FRAME_CNT(frame_cnt), .LEN_MIN(len_min), .LEN_MAX(len_max),
        .TX_DATA(data), .TX_META(meta), .TX_SOF(sof), .TX_EOF(eof),
        .TX_SOF_POS(sof_pos), .TX_EOF_POS(eof_pos),
        .TX_SRC_RDY(src_rdy), .TX_DST_RDY(dst_rdy),
        .BUSY(busy), .DONE(done), .SENT_FRAMES(sent)
    );

    int errs, checks, cyc;
    reg_t expq[$];
    int exp_words;
    bit mon_en, rand_rdy, in_frame, pad_seen;
    int eofs, sofs_after, words, last_xfer, stop_cyc;

    task automatic chk(string tag, v_t got, v_t exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expand the frame list into the region stream the sink should see
    task automatic model_build(int unsigned cnt, int unsigned lmin,
                               int unsigned lmax, int unsigned nfr);
        int unsigned lo, hi, l, nreg, total;
        reg_t e;
        lo = (lmin == 0) ? 1 : lmin;
        hi = (lmax < lo) ? lo : lmax;
        l = lo;
        total = 0;
        expq.delete();
        for (int unsigned k = 0; k < nfr; k++) begin
            nreg = (l + R - 1) / R;
            for (int unsigned g = 0; g < nreg; g++) begin
                e = '0;
                e.sof = (g == 0);
                e.eof = (g == nreg - 1);
                if (e.eof) e.pos = EW'((l - 1) % R);
                if (e.sof) e.meta = META_WIDTH'(k);
                for (int unsigned j = 0; j < R; j++)
                    if (g * R + j < l)
                        e.data[j*ITEM_WIDTH +: ITEM_WIDTH] = ITEM_WIDTH'(g * R + j + k);
                expq.push_back(e);
            end
            total += nreg;
            l = (l + 1 > hi) ? lo : l + 1;
        end
        exp_words = int'((total + REGIONS - 1) / REGIONS);
        if (cnt == 0) exp_words = 0;
    endtask

    task automatic check_zero(string tag);
        chk(tag, v_t'({src_rdy, sof, eof, busy, done, sent, meta,
                       sof_pos, eof_pos, |data}), '0);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        dst_rdy = 1;
        forever begin
            @(posedge clk);
            #1;
            dst_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Transfer monitor: sampled mid-cycle, the transfer happens at the next edge
    initial begin
        reg_t e;
        logic [DW+REGIONS*(META_WIDTH+SW+EW+2):0] cur, snap;
        logic sf, ef, nonempty, stall_prev, have;
        stall_prev = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            cur = {src_rdy, sof, eof, sof_pos, eof_pos, meta, data};
            if (mon_en && rst_n) begin
                if (stall_prev) chk("stall_hold", v_t'(cur == snap), 1);
                stall_prev = src_rdy && !dst_rdy;
                snap = cur;
                if (src_rdy && dst_rdy) begin
                    words++;
                    last_xfer = cyc;
                    nonempty = 0;
                    chk("sof_pos", v_t'(sof_pos), 0);
                    for (int r = 0; r < REGIONS; r++) begin
                        sf = sof[r];
                        ef = eof[r];
                        if (sf || in_frame) begin
                            nonempty = 1;
                            chk("pad_order", v_t'(pad_seen), 0);
                            if (sf && cyc >= stop_cyc + 1) sofs_after++;
                            have = (expq.size() != 0);
                            chk("exp_avail", v_t'(have), 1);
                            e = have ? expq.pop_front() : '0;
                            chk("sof", v_t'(sf), v_t'(e.sof));
                            chk("eof", v_t'(ef), v_t'(e.eof));
                            chk("eof_pos", v_t'(ef ? eof_pos[r*EW +: EW] : '0), v_t'(e.pos));
                            chk("meta", v_t'(meta[r*META_WIDTH +: META_WIDTH]), v_t'(e.meta));
                            chk("data", data[r*RB +: RB], e.data);
                            if (ef) eofs++;
                            in_frame = !ef;
                        end else begin
                            pad_seen = 1;
                            chk("pad_zero", v_t'({ef, meta[r*META_WIDTH +: META_WIDTH],
                                                  |data[r*RB +: RB]}), 0);
                        end
                    end
                    chk("word_nonempty", v_t'(nonempty), 1);
                end
            end else begin
                stall_prev = 0;
            end
        end
    end

    task automatic run(int unsigned cnt, int unsigned lmin, int unsigned lmax,
                       bit rmode, int stop_at, bit poke_start);
        bit got_done;
        int done_cyc;
        model_build(cnt, lmin, lmax, (cnt == 0) ? 300 : cnt);
        in_frame = 0;
        pad_seen = 0;
        eofs = 0;
        sofs_after = 0;
        words = 0;
        last_xfer = -10;
        stop_cyc = 1 << 30;
        rand_rdy = rmode;
        frame_cnt = cnt;
        len_min = LEN_WIDTH'(lmin);
        len_max = LEN_WIDTH'(lmax);
        mon_en = 1;
        start = 1;
        @(posedge clk);
        #2;
        start = 0;
        chk("first_word_vld", v_t'(src_rdy), 1);
        chk("busy_run", v_t'(busy), 1);
        got_done = 0;
        done_cyc = -1;
        for (int i = 0; i < 5000 && !got_done; i++) begin
            @(posedge clk);
            #2;
            start = poke_start && (i == 3);
            stop = (stop_at > 0) && (i == stop_at);
            if (stop) stop_cyc = cyc;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        start = 0;
        stop = 0;
        chk("done_seen", v_t'(got_done), 1);
        chk("done_timing", v_t'(done_cyc), v_t'(last_xfer + 1));
        chk("sent_vs_eofs", v_t'(sent), v_t'(eofs));
        chk("frame_closed", v_t'(in_frame), 0);
        if (cnt != 0) begin
            chk("sent_frames", v_t'(sent), v_t'(cnt));
            chk("words", v_t'(words), v_t'(exp_words));
            chk("queue_empty", v_t'(expq.size()), 0);
        end else begin
            chk("sof_after_stop", v_t'(sofs_after), 0);
        end
        @(posedge clk);
        #2;
        chk("done_pulse", v_t'(done), 0);
        chk("busy_fall", v_t'(busy), 0);
        chk("idle_vld", v_t'(src_rdy), 0);
        rand_rdy = 0;
    endtask

    initial begin
        errs = 0;
        checks = 0;
        rst_n = 0;
        start = 0;
        stop = 0;
        frame_cnt = 0;
        len_min = 0;
        len_max = 0;
        mon_en = 0;
        rand_rdy = 0;
        #12;
        check_zero("reset_state");
        @(posedge clk);
        #1 rst_n = 1;
        run(3, 32, 32, 0, 0, 0);
        run(2, 70, 70, 0, 0, 0);
        run(5, 1, 3, 0, 0, 0);
        run(20, 0, 100, 1, 0, 1);
        run(10, 50, 20, 1, 0, 0);
        run(0, 40, 90, 0, 10, 0);
        model_build(0, 100, 100, 20);
        frame_cnt = 0;
        len_min = 100;
        len_max = 100;
        start = 1;
        @(posedge clk);
        #2 start = 0;
        repeat (3) @(posedge clk);
        mon_en = 0;
        #3 rst_n = 0;
        #1 check_zero("reset_async");
        @(posedge clk);
        #1 rst_n = 1;
        run(4, 60, 65, 1, 0, 0);
        for (int t = 0; t < 3; t++)
            run($urandom_range(1, 12), $urandom_range(0, 80),
                $urandom_range(0, 120), 1, 0, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
